// File: rtl/eq_band_sequencer.sv
// Time-multiplexed symmetric-FIR sequencer: one shared MAC computes every EQ band per sample.
// Optional feature: define EQ_BAND_SAT_EN to saturate band results instead of wrapping.
module eq_band_sequencer #(
    parameter int unsigned NUM_BANDS  = 3,
    parameter int unsigned TAPS       = 26,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 48
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [31:0]           d_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_BANDS*32-1:0]      band_out,
    output logic                         out_valid,
    output logic                         busy,
    input  logic                         coef_we,
    input  logic [$clog2(NUM_BANDS)-1:0] coef_band,
    input  logic [$clog2(TAPS)-1:0]      coef_idx,
    input  logic signed [COEF_WIDTH+1:0] coef_data,
    output logic                         coef_err
);

    localparam int unsigned BW  = $clog2(NUM_BANDS);
    localparam int unsigned TW  = $clog2(TAPS);
    localparam int unsigned XN  = 2 * TAPS - 1;
    localparam int unsigned XW  = $clog2(XN);
    localparam int unsigned XDW = 25;
    localparam int unsigned PW  = XDW + 1;
    localparam int unsigned CW  = COEF_WIDTH + 2;
    localparam int unsigned MW  = CW + PW;

    localparam logic [TW-1:0] TLast = TW'(TAPS - 1);
    localparam logic [BW-1:0] BLast = BW'(NUM_BANDS - 1);
    localparam logic [XW-1:0] XMir  = XW'(2 * TAPS - 2);

    typedef enum logic {StIdle, StMac} state_e;

    state_e                      r_state;
    logic signed [XDW-1:0]       r_x    [XN];
    logic signed [CW-1:0]        r_coef [NUM_BANDS][TAPS];
    logic signed [31:0]          r_res  [NUM_BANDS];
    logic [TW-1:0]               r_t;
    logic [BW-1:0]               r_b;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [NUM_BANDS*32-1:0]     r_band_out;
    logic                        r_out_valid;
    logic                        r_coef_err;

    logic                        w_accept;
    logic                        w_coef_ok;
    logic                        w_last_tap;
    logic                        w_last_band;
    logic signed [31:0]          w_din_b;
    logic signed [XDW-1:0]       w_xin;
    logic [XW-1:0]               w_lo_idx;
    logic [XW-1:0]               w_hi_idx;
    logic signed [XDW-1:0]       w_x_lo;
    logic signed [XDW-1:0]       w_x_hi;
    logic signed [PW-1:0]        w_pair;
    logic signed [CW-1:0]        w_coef;
    logic signed [MW-1:0]        w_prod;
    logic signed [ACC_WIDTH-1:0] w_term;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_biased;
    logic signed [ACC_WIDTH-1:0] w_div;
    logic [31:0]                 w_res;

    assign in_ready  = (r_state == StIdle);
    assign busy      = (r_state == StMac);
    assign band_out  = r_band_out;
    assign out_valid = r_out_valid;
    assign coef_err  = r_coef_err;

    assign w_accept    = in_valid && (r_state == StIdle);
    assign w_coef_ok   = coef_we && (r_state == StIdle) && !in_valid
                         && (int'(coef_band) < NUM_BANDS) && (int'(coef_idx) < TAPS);
    assign w_last_tap  = (r_t == TLast);
    assign w_last_band = (r_b == BLast);

    // Bias negative samples so the arithmetic shift truncates toward zero.
    assign w_din_b = d_in + (d_in[31] ? 32'sd127 : 32'sd0);
    assign w_xin   = XDW'(w_din_b >>> 7);

    always_comb begin
        w_lo_idx = XW'(r_t);
        w_hi_idx = XMir - w_lo_idx;
        w_x_lo   = r_x[w_lo_idx];
        w_x_hi   = r_x[w_hi_idx];
        w_coef   = r_coef[r_b][r_t];
        if (w_last_tap) begin
            w_pair = {w_x_lo[XDW-1], w_x_lo};
        end else begin
            w_pair = {w_x_lo[XDW-1], w_x_lo} + {w_x_hi[XDW-1], w_x_hi};
        end
        w_prod   = {{PW{w_coef[CW-1]}}, w_coef} * {{CW{w_pair[PW-1]}}, w_pair};
        w_term   = {{(ACC_WIDTH-MW){w_prod[MW-1]}}, w_prod};
        w_sum    = (r_t == '0) ? w_term : r_acc + w_term;
        w_biased = w_sum + {{(ACC_WIDTH-4){1'b0}}, {4{w_sum[ACC_WIDTH-1]}}};
        w_div    = w_biased >>> 4;
`ifdef EQ_BAND_SAT_EN
        if ((w_div[ACC_WIDTH-1:31] == '0) || (w_div[ACC_WIDTH-1:31] == '1)) begin
            w_res = w_div[31:0];
        end else begin
            w_res = w_div[ACC_WIDTH-1] ? 32'h8000_0000 : 32'h7fff_ffff;
        end
`else
        w_res = 32'(w_div);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_t         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_band_out  <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < XN; k++) r_x[k] <= '0;
            for (int i = 0; i < NUM_BANDS; i++) r_res[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_x[0] <= w_xin;
                        for (int k = 1; k < XN; k++) r_x[k] <= r_x[k-1];
                        r_t     <= '0;
                        r_b     <= '0;
                        r_state <= StMac;
                    end
                end
                StMac: begin
                    r_acc <= w_sum;
                    if (w_last_tap) begin
                        r_res[r_b] <= w_res;
                        r_t        <= '0;
                        if (w_last_band) begin
                            // Last band bypasses r_res so all bands publish on this edge.
                            for (int i = 0; i < NUM_BANDS; i++) begin
                                r_band_out[32*i +: 32] <= (i == NUM_BANDS - 1) ? w_res : r_res[i];
                            end
                            r_out_valid <= 1'b1;
                            r_state     <= StIdle;
                        end else begin
                            r_b <= r_b + BW'(1);
                        end
                    end else begin
                        r_t <= r_t + TW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coef_err <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                for (int t = 0; t < TAPS; t++) r_coef[b][t] <= '0;
            end
        end else begin
            r_coef_err <= coef_we && !w_coef_ok;
            if (w_coef_ok) r_coef[coef_band][coef_idx] <= coef_data;
        end
    end

endmodule

// File: tb/tb_eq_band_sequencer.sv
// Self-checking bench for eq_band_sequencer against a direct-form symmetric FIR reference.
`timescale 1ns/1ps
module tb_eq_band_sequencer;

    localparam int NB  = 3;
    localparam int NT  = 26;
    localparam int NX  = 2 * NT - 1;
    localparam int LAT = NB * NT;
    localparam longint MaxI = 64'sd2147483647;
    localparam longint MinI = -64'sd2147483648;

    typedef logic [NB*32-1:0] bands_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [31:0] d_in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    bands_t             band_out;
    logic               out_valid;
    logic               busy;
    logic               coef_we = 1'b0;
    logic [1:0]         coef_band = '0;
    logic [4:0]         coef_idx = '0;
    logic signed [17:0] coef_data = '0;
    logic               coef_err;

    int checks = 0;
    int failures = 0;

    int hist [NX];
    int cm   [NB][NT];

    eq_band_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in      (d_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .band_out  (band_out),
        .out_valid (out_valid),
        .busy      (busy),
        .coef_we   (coef_we),
        .coef_band (coef_band),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .coef_err  (coef_err)
    );

    always #5 clk = ~clk;

    // Reference model: full-length FIR with mirrored coefficients over a sample history.
    function automatic void model_reset();
        for (int k = 0; k < NX; k++) hist[k] = 0;
        for (int b = 0; b < NB; b++) for (int t = 0; t < NT; t++) cm[b][t] = 0;
    endfunction

    function automatic void model_push(input int d);
        for (int k = NX - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d / 128;
    endfunction

    function automatic logic [31:0] model_band(input int b);
        longint s = 0;
        longint q;
        for (int k = 0; k < NX; k++) begin
            s += longint'(cm[b][(k < NT) ? k : NX - 1 - k]) * longint'(hist[k]);
        end
        q = s / 16;
`ifdef EQ_BAND_SAT_EN
        if (q > MaxI) q = MaxI;
        else if (q < MinI) q = MinI;
`endif
        return q[31:0];
    endfunction

    function automatic bands_t model_all();
        bands_t r;
        for (int b = 0; b < NB; b++) r[32*b +: 32] = model_band(b);
        return r;
    endfunction

    task automatic apply_reset();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic write_coef(input int b, input int i, input int data, output logic err);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_band = 2'(b);
        coef_idx  = 5'(i);
        coef_data = 18'(data);
        @(posedge clk);
        if (b < NB && i < NT) cm[b][i] = data;
        #1;
        err = coef_err;
        coef_we = 1'b0;
    endtask

    task automatic load_random_coefs();
        logic e;
        for (int b = 0; b < NB; b++)
            for (int t = 0; t < NT; t++)
                write_coef(b, t, int'($urandom_range(0, 262143)) - 131072, e);
    endtask

    task automatic run_sample(input int d, output bands_t got, output int lat);
        @(negedge clk);
        d_in = d;
        in_valid = 1'b1;
        for (int w = 0; w < 200 && !in_ready; w++) @(negedge clk);
        @(posedge clk);
        model_push(d);
        #1 in_valid = 1'b0;
        got = 'x;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got = band_out;
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_out(output bands_t got, output int waited);
        got = 'x;
        waited = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got = band_out;
                waited = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bands_t got;
        int lat;
        apply_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL reset_coef_err got=%b want=0", coef_err); end
        checks++; if (band_out !== '0) begin failures++; $display("FAIL reset_band_out got=%h want=0", band_out); end
        run_sample(int'($urandom), got, lat);
        checks++; if (lat != LAT) begin failures++; $display("FAIL reset_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (got !== '0) begin failures++; $display("FAIL reset_zero_coefs got=%h want=0", got); end
    endtask

    task automatic test_impulse();
        bands_t got;
        int lat;
        logic e;
        logic [31:0] exp0;
        apply_reset();
        for (int t = 0; t < NT; t++) write_coef(0, t, t + 1, e);
        for (int n = 0; n < NX + 1; n++) begin
            run_sample((n == 0) ? 2048 : 0, got, lat);
            exp0 = (n < NT) ? 32'(n + 1) : ((n < NX) ? 32'(NX - n) : 32'd0);
            checks++;
            if (got !== {64'd0, exp0}) begin
                failures++;
                $display("FAIL impulse n=%0d got=%h want=%h", n, got, {64'd0, exp0});
            end
            checks++;
            if (lat != LAT) begin failures++; $display("FAIL impulse_latency n=%0d got=%0d want=%0d", n, lat, LAT); end
        end
    endtask

    task automatic test_rounding();
        bands_t got;
        bands_t want;
        int lat;
        logic e;
        apply_reset();
        write_coef(0, NT - 1, 16, e);
        for (int n = 0; n < NT; n++) begin
            run_sample((n == 0) ? -200 : 0, got, lat);
            want = model_all();
            checks++;
            if (got !== want) begin failures++; $display("FAIL rounding_model n=%0d got=%h want=%h", n, got, want); end
        end
        checks++;
        if (got[31:0] !== 32'hffff_ffff) begin
            failures++;
            $display("FAIL rounding_centre got=%h want=ffffffff", got[31:0]);
        end
    endtask

    task automatic test_overflow();
        bands_t got;
        bands_t want;
        int lat;
        logic e;
        apply_reset();
        for (int t = 0; t < NT; t++) write_coef(0, t, 131071, e);
        for (int n = 0; n < NX; n++) run_sample(32'h7fff_ffff, got, lat);
        want = model_all();
        checks++;
        if (got !== want) begin failures++; $display("FAIL overflow_model got=%h want=%h", got, want); end
`ifdef EQ_BAND_SAT_EN
        checks++;
        if (got[31:0] !== 32'h7fff_ffff) begin failures++; $display("FAIL overflow_sat got=%h want=7fffffff", got[31:0]); end
`endif
    endtask

    task automatic test_coef_err();
        bands_t got;
        bands_t want;
        int lat;
        int v;
        logic e;
        apply_reset();
        load_random_coefs();
        write_coef(3, 4, 99, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL coef_bad_band got=%b want=1", e); end
        write_coef(1, NT, 99, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL coef_bad_idx got=%b want=1", e); end
        write_coef(2, 7, -5000, e);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL coef_good got=%b want=0", e); end
        run_sample(int'($urandom), got, lat);
        want = model_all();
        checks++; if (got !== want) begin failures++; $display("FAIL coef_idle_result got=%h want=%h", got, want); end

        // Write attempt at tap 10 of band 0 while the MAC is running.
        v = int'($urandom);
        @(negedge clk); d_in = v; in_valid = 1'b1;
        @(posedge clk); model_push(v);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        coef_we = 1'b1; coef_band = 2'd0; coef_idx = 5'd5;
        coef_data = 18'((cm[0][5] == 777) ? 778 : 777);
        @(posedge clk); #1;
        checks++; if (coef_err !== 1'b1) begin failures++; $display("FAIL coef_busy_err got=%b want=1", coef_err); end
        @(negedge clk); coef_we = 1'b0;
        @(posedge clk); #1;
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL coef_err_pulse got=%b want=0", coef_err); end
        wait_out(got, lat);
        want = model_all();
        checks++; if (got !== want) begin failures++; $display("FAIL coef_busy_result got=%h want=%h", got, want); end

        // Write in the same cycle as a sample accept.
        v = int'($urandom);
        @(negedge clk);
        d_in = v; in_valid = 1'b1;
        coef_we = 1'b1; coef_band = 2'd1; coef_idx = 5'd3;
        coef_data = 18'((cm[1][3] == 4321) ? 4320 : 4321);
        @(posedge clk); model_push(v);
        #1 in_valid = 1'b0; coef_we = 1'b0;
        checks++; if (coef_err !== 1'b1) begin failures++; $display("FAIL coef_accept_err got=%b want=1", coef_err); end
        wait_out(got, lat);
        want = model_all();
        checks++; if (got !== want) begin failures++; $display("FAIL coef_accept_result got=%h want=%h", got, want); end
        run_sample(int'($urandom), got, lat);
        want = model_all();
        checks++; if (got !== want) begin failures++; $display("FAIL coef_after_result got=%h want=%h", got, want); end
    endtask

    task automatic test_reset_mid_mac();
        bands_t got;
        bands_t want;
        int lat;
        int seen;
        apply_reset();
        load_random_coefs();
        for (int n = 0; n < 3; n++) run_sample(int'($urandom), got, lat);
        @(negedge clk); d_in = int'($urandom); in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        checks++; if (band_out !== '0) begin failures++; $display("FAIL midrst_band_out got=%h want=0", band_out); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_output got=%0d want=0", seen); end
        load_random_coefs();
        run_sample(int'($urandom), got, lat);
        want = model_all();
        checks++; if (got !== want) begin failures++; $display("FAIL midrst_line_zeroed got=%h want=%h", got, want); end
    endtask

    task automatic test_back_to_back();
        bands_t exp_q[$];
        int     acc_q[$];
        bands_t want;
        int last_acc = -1000;
        int n_acc = 0, n_ov = 0;
        int ready_bad = 0, lat_bad = 0, val_bad = 0, b2b_bad = 0;
        logic take;
        logic exp_rdy;
        apply_reset();
        load_random_coefs();
        @(negedge clk); d_in = 1280; in_valid = 1'b1;
        for (int c = 0; c < 400 && n_ov < 3; c++) begin
            if (c > 0) @(negedge clk);
            exp_rdy = ((c - 1 - last_acc) >= LAT);
            if (in_ready !== exp_rdy) ready_bad++;
            if (n_acc == 3) in_valid = 1'b0;
            take = in_valid && in_ready;
            if (take && n_acc > 0 && out_valid !== 1'b1) b2b_bad++;
            @(posedge clk);
            if (take) begin
                last_acc = c;
                n_acc++;
                acc_q.push_back(c);
                model_push(1280);
                exp_q.push_back(model_all());
            end
            #1;
            if (out_valid && acc_q.size() > 0) begin
                n_ov++;
                if (c - acc_q.pop_front() != LAT) lat_bad++;
                want = exp_q.pop_front();
                if (band_out !== want) val_bad++;
            end
        end
        in_valid = 1'b0;
        checks++; if (n_acc != 3) begin failures++; $display("FAIL b2b_accepts got=%0d want=3", n_acc); end
        checks++; if (n_ov != 3) begin failures++; $display("FAIL b2b_outputs got=%0d want=3", n_ov); end
        checks++; if (ready_bad != 0) begin failures++; $display("FAIL b2b_in_ready bad_cycles=%0d want=0", ready_bad); end
        checks++; if (b2b_bad != 0) begin failures++; $display("FAIL b2b_accept_on_out_valid bad=%0d want=0", b2b_bad); end
        checks++; if (lat_bad != 0) begin failures++; $display("FAIL b2b_latency bad=%0d want=0", lat_bad); end
        checks++; if (val_bad != 0) begin failures++; $display("FAIL b2b_values bad=%0d want=0", val_bad); end
    endtask

    task automatic test_random();
        bands_t got;
        bands_t want;
        int lat;
        apply_reset();
        load_random_coefs();
        for (int n = 0; n < 60; n++) begin
            run_sample(int'($urandom), got, lat);
            want = model_all();
            checks++;
            if (got !== want || lat != LAT) begin
                failures++;
                $display("FAIL random n=%0d got=%h lat=%0d want=%h lat=%0d", n, got, lat, want, LAT);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_rounding();
        test_overflow();
        test_coef_err();
        test_reset_mid_mac();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
